// File: rtl/shifting_pipo_pkg.sv
// Shared constants and types for the keypad digit shift register.
package shifting_pipo_pkg;

    localparam int DIGIT_W_DEF = 4;
    localparam int DEPTH_DEF   = 4;
    localparam int CNT_W_DEF   = $clog2(DEPTH_DEF + 1);

    typedef logic [DIGIT_W_DEF-1:0] digit_t;

endpackage

// File: rtl/shifting_pipo_stage.sv
// One digit-wide storage stage of the keypad shift register.
module shifting_pipo_stage
    import shifting_pipo_pkg::*;
#(
    parameter int DIGIT_W = DIGIT_W_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               ce,
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    logic [DIGIT_W-1:0] r_q;

    // clr wins over ce so a cleared lock never captures a stray digit.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else if (ce) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/shifting_pipo.sv
// Keypad digit shift register: newest digit in LSBs, last DEPTH digits in parallel.
// Define SHIFTING_PIPO_COUNT_EN to add the saturating digit count and full flag.
module shifting_pipo
    import shifting_pipo_pkg::*;
#(
    parameter int DIGIT_W = DIGIT_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       ce,
    input  logic [DIGIT_W-1:0]         data_i,
    output logic [DIGIT_W*DEPTH-1:0]   data_o
`ifdef SHIFTING_PIPO_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
`endif
);

    logic [DIGIT_W-1:0] w_stage_q [DEPTH];

    // Stage 0 holds the newest digit; each later stage takes its neighbour's value.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [DIGIT_W-1:0] w_d;

        if (k == 0) begin : g_first
            assign w_d = data_i;
        end else begin : g_chain
            assign w_d = w_stage_q[k-1];
        end

        shifting_pipo_stage #(
            .DIGIT_W (DIGIT_W)
        ) u_stage (
            .clk (clk),
            .clr (clr),
            .ce  (ce),
            .d   (w_d),
            .q   (w_stage_q[k])
        );

        assign data_o[k*DIGIT_W +: DIGIT_W] = w_stage_q[k];
    end

`ifdef SHIFTING_PIPO_COUNT_EN
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] r_count;
    logic             r_full;

    // full is kept in step with count so it can gate saturation directly.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (ce && !r_full) begin
            r_count <= r_count + 1'b1;
            r_full  <= (r_count == CNT_W'(DEPTH - 1));
        end
    end

    assign count = r_count;
    assign full  = r_full;
`endif

endmodule

// File: tb/tb_shifting_pipo.sv
// Directed self-checking bench for shifting_pipo (optionally with SHIFTING_PIPO_COUNT_EN).
module tb_shifting_pipo;

    logic        clk = 1'b0;
    logic        clr;
    logic        ce;
    logic [3:0]  data_i;
    logic [15:0] data_o;
`ifdef SHIFTING_PIPO_COUNT_EN
    logic [2:0]  count;
    logic        full;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shifting_pipo #(
        .DIGIT_W (4),
        .DEPTH   (4)
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .ce     (ce),
        .data_i (data_i),
        .data_o (data_o)
`ifdef SHIFTING_PIPO_COUNT_EN
        ,
        .count  (count),
        .full   (full)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int exp_cnt, input logic exp_full);
`ifdef SHIFTING_PIPO_COUNT_EN
        chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
        chk({tag, "_full"},  32'(full),  32'(exp_full));
`endif
    endtask

    // Apply inputs away from the edge, then sample 1 time unit after it.
    task automatic step(input logic c, input logic e, input logic [3:0] d);
        clr    = c;
        ce     = e;
        data_i = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; ce = 1'b1; data_i = 4'h0;
        #2;

        step(1'b1, 1'b1, 4'h0);
        step(1'b1, 1'b1, 4'h0);
        chk("clear", 32'(data_o), 32'h0000);
        chk_cnt("clear", 0, 1'b0);

        step(1'b0, 1'b1, 4'h1);
        chk("shift1", 32'(data_o), 32'h0001);
        chk_cnt("shift1", 1, 1'b0);
        step(1'b0, 1'b1, 4'h2);
        chk("shift2", 32'(data_o), 32'h0012);
        chk_cnt("shift2", 2, 1'b0);

        step(1'b0, 1'b0, 4'h7);
        chk("hold1", 32'(data_o), 32'h0012);
        step(1'b0, 1'b0, 4'h7);
        chk("hold2", 32'(data_o), 32'h0012);
        chk_cnt("hold", 2, 1'b0);

        step(1'b0, 1'b1, 4'h3);
        chk("fill3", 32'(data_o), 32'h0123);
        chk_cnt("fill3", 3, 1'b0);
        step(1'b0, 1'b1, 4'h4);
        chk("fill4", 32'(data_o), 32'h1234);
        chk_cnt("fill4", 4, 1'b1);

        step(1'b0, 1'b1, 4'h5);
        chk("overflow", 32'(data_o), 32'h2345);
        chk_cnt("overflow", 4, 1'b1);

        // ce and data_i pulse between edges but are low/stable at the edge.
        clr = 1'b0; ce = 1'b0; data_i = 4'h6;
        #2 ce = 1'b1; data_i = 4'hE;
        #2 ce = 1'b0; data_i = 4'h6;
        @(posedge clk);
        #1;
        chk("async_ce", 32'(data_o), 32'h2345);

        step(1'b1, 1'b1, 4'h9);
        chk("clr_prio", 32'(data_o), 32'h0000);
        chk_cnt("clr_prio", 0, 1'b0);
        step(1'b0, 1'b1, 4'h9);
        chk("after_clr", 32'(data_o), 32'h0009);
        chk_cnt("after_clr", 1, 1'b0);

        step(1'b0, 1'b1, 4'hA);
        chk("hi_a", 32'(data_o), 32'h009A);
        step(1'b0, 1'b1, 4'hB);
        chk("hi_b", 32'(data_o), 32'h09AB);
        step(1'b0, 1'b1, 4'hC);
        chk("hi_c", 32'(data_o), 32'h9ABC);
        step(1'b0, 1'b1, 4'hF);
        chk("hi_f", 32'(data_o), 32'hABCF);
        step(1'b0, 1'b0, 4'h0);
        chk("hi_hold", 32'(data_o), 32'hABCF);
        chk_cnt("hi_hold", 4, 1'b1);

        step(1'b1, 1'b0, 4'h3);
        chk("clr_no_ce", 32'(data_o), 32'h0000);
        chk_cnt("clr_no_ce", 0, 1'b0);
        step(1'b0, 1'b0, 4'h3);
        chk("idle_zero", 32'(data_o), 32'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
